// File: rtl/sa_host_responder.sv
// sa_host_responder: bridges host valid/ready streams to the systolic array's
// dvalid/din/dout beat interface. LOAD pushes host beats into the array at up
// to one per cycle. STORE asks the array for one beat at a time and presents
// each one on the host sink until it is accepted.
module sa_host_responder #(
  parameter int DIN_BITS = 128,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          axi_sm_mode,
  input  logic                init_axi_txn,
  input  logic [LEN_BITS-1:0] txn_len,
  output logic                dvalid,
  output logic [DIN_BITS-1:0] din,
  input  logic [DIN_BITS-1:0] dout,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DIN_BITS-1:0] src_data,
  output logic                snk_valid,
  input  logic                snk_ready,
  output logic [DIN_BITS-1:0] snk_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {IDLE, LOAD, S_REQ, S_WAIT, S_HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [DIN_BITS-1:0] din_q, din_d, snk_data_q, snk_data_d;
  logic                dvalid_q, dvalid_d, src_ready_q, src_ready_d;
  logic                snk_valid_q, snk_valid_d, busy_q, busy_d;
  logic                done_q, done_d, err_q, err_d;
  logic                last_beat;

  // A length of 0 encodes 2^LEN_BITS. Starting at 0 and stopping when the
  // count reads 1 handles that case without special logic.
  assign last_beat = (cnt_q == LEN_BITS'(1));

  // Next-state and registered-output decode. Every output is computed for
  // the state being entered, so the flops line up exactly with the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_d       = din_q;
    snk_data_d  = snk_data_q;
    dvalid_d    = 1'b0;
    src_ready_d = 1'b0;
    snk_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_axi_txn) begin
          case (axi_sm_mode)
            2'b01: begin
              cnt_d       = txn_len;
              state_d     = LOAD;
              src_ready_d = 1'b1;
            end
            2'b10: begin
              cnt_d    = txn_len;
              state_d  = S_REQ;
              dvalid_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      LOAD: begin
        src_ready_d = 1'b1;
        if (src_valid && src_ready_q) begin
          din_d    = src_data;
          dvalid_d = 1'b1;
          cnt_d    = cnt_q - LEN_BITS'(1);
          if (last_beat) begin
            // The final beat leaves together with done.
            state_d     = DONE;
            done_d      = 1'b1;
            src_ready_d = 1'b0;
          end
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        // The array presents the requested beat on dout in this cycle.
        snk_data_d  = dout;
        snk_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        snk_valid_d = 1'b1;
        if (snk_ready) begin
          snk_valid_d = 1'b0;
          cnt_d       = cnt_q - LEN_BITS'(1);
          if (last_beat) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_REQ;
            dvalid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any partial transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      din_q       <= '0;
      snk_data_q  <= '0;
      dvalid_q    <= 1'b0;
      src_ready_q <= 1'b0;
      snk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_q       <= din_d;
      snk_data_q  <= snk_data_d;
      dvalid_q    <= dvalid_d;
      src_ready_q <= src_ready_d;
      snk_valid_q <= snk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign dvalid    = dvalid_q;
  assign din       = din_q;
  assign src_ready = src_ready_q;
  assign snk_valid = snk_valid_q;
  assign snk_data  = snk_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sa_host_responder.sv
// Bench for sa_host_responder: directed and randomized LOAD/STORE transfers
// checked against a transaction-level model of the host/array protocol.
module tb_sa_host_responder;
  localparam int DW = 128;
  localparam int LW = 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic [1:0]    axi_sm_mode = 2'b00;
  logic          init_axi_txn = 1'b0;
  logic [LW-1:0] txn_len = '0;
  logic          dvalid, src_ready, snk_valid, busy, done, err;
  logic [DW-1:0] din, snk_data;
  logic [DW-1:0] dout = '0, src_data = '0;
  logic          src_valid = 1'b0, snk_ready = 1'b0;

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] last_din = '0;

  sa_host_responder #(.DIN_BITS(DW), .LEN_BITS(LW)) dut (
    .clk(clk), .reset(reset), .axi_sm_mode(axi_sm_mode), .init_axi_txn(init_axi_txn),
    .txn_len(txn_len), .dvalid(dvalid), .din(din), .dout(dout),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
    chk({tag, "_dvalid"}, DW'(dvalid), DW'(0));
    chk({tag, "_err"}, DW'(err), DW'(0));
    chk({tag, "_src_ready"}, DW'(src_ready), DW'(0));
    chk({tag, "_snk_valid"}, DW'(snk_valid), DW'(0));
  endtask

  // LOAD of n beats (1..256). p_valid: percent chance src_valid is high per
  // cycle. poke_at >= 0 fires a stray init_axi_txn once that many beats are in.
  task automatic run_load(input int n, input int p_valid, input int poke_at);
    int acc = 0, pulses = 0, cyc = 0;
    bit fin = 0, poked = 0, v, hs;
    logic [DW-1:0] d;
    axi_sm_mode = 2'b01; txn_len = LW'(n); init_axi_txn = 1'b1;
    tick();
    init_axi_txn = 1'b0;
    chk("load_start_busy", DW'(busy), DW'(1));
    chk("load_start_ready", DW'(src_ready), DW'(1));
    chk("load_start_dvalid", DW'(dvalid), DW'(0));
    while (!fin && cyc < n * 40 + 50) begin
      cyc++;
      v = ($urandom_range(99) < p_valid);
      d = rnd_word();
      src_valid = v; src_data = d;
      init_axi_txn = 1'b0;
      if (poke_at >= 0 && !poked && acc >= poke_at) begin
        poked = 1;
        init_axi_txn = 1'b1;
        axi_sm_mode = 2'($urandom_range(3));
        txn_len = LW'($urandom_range(255));
      end
      hs = v && (acc < n);
      if (hs) acc++;
      tick();
      chk("load_dvalid", DW'(dvalid), DW'(hs));
      if (hs) begin
        pulses++;
        last_din = d;
      end
      chk("load_din", din, last_din);
      chk("load_done", DW'(done), DW'(hs && acc == n));
      chk("load_err", DW'(err), DW'(0));
      chk("load_busy", DW'(busy), DW'(1));
      chk("load_ready", DW'(src_ready), DW'(acc < n));
      chk("load_snk_valid", DW'(snk_valid), DW'(0));
      if (hs && acc == n) fin = 1;
    end
    init_axi_txn = 1'b0; src_valid = 1'b0;
    chk("load_finished", DW'(fin), DW'(1));
    chk("load_pulses", DW'(pulses), DW'(n));
    tick();
    chk_idle("load_after");
    chk("load_after_din", din, last_din);
  endtask

  // STORE of n beats; each beat stalls snk_ready for a random 0..max_stall
  // cycles, except beat 0 which uses first_stall when it is >= 0.
  task automatic run_store(input int n, input int max_stall, input int first_stall);
    logic [DW-1:0] x;
    int k;
    axi_sm_mode = 2'b10; txn_len = LW'(n); init_axi_txn = 1'b1;
    tick();
    init_axi_txn = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("st_req_dvalid", DW'(dvalid), DW'(1));
      chk("st_req_snk_valid", DW'(snk_valid), DW'(0));
      chk("st_req_busy", DW'(busy), DW'(1));
      chk("st_req_done", DW'(done), DW'(0));
      x = rnd_word();
      tick();
      dout = x;  // array answers one cycle after the request
      chk("st_wait_dvalid", DW'(dvalid), DW'(0));
      chk("st_wait_snk_valid", DW'(snk_valid), DW'(0));
      tick();
      dout = rnd_word();
      k = (i == 0 && first_stall >= 0) ? first_stall : $urandom_range(max_stall);
      for (int s = 0; s <= k; s++) begin
        snk_ready = (s == k);
        chk("st_hold_snk_valid", DW'(snk_valid), DW'(1));
        chk("st_hold_snk_data", snk_data, x);
        chk("st_hold_dvalid", DW'(dvalid), DW'(0));
        chk("st_hold_err", DW'(err), DW'(0));
        tick();
      end
      snk_ready = 1'b0;
    end
    chk("st_done", DW'(done), DW'(1));
    chk("st_done_dvalid", DW'(dvalid), DW'(0));
    chk("st_done_snk_valid", DW'(snk_valid), DW'(0));
    tick();
    chk_idle("st_after");
  endtask

  task automatic bad_mode(input logic [1:0] m);
    axi_sm_mode = m; txn_len = LW'($urandom_range(255)); init_axi_txn = 1'b1;
    tick();
    init_axi_txn = 1'b0;
    chk("err_pulse", DW'(err), DW'(1));
    chk("err_busy", DW'(busy), DW'(0));
    chk("err_dvalid", DW'(dvalid), DW'(0));
    chk("err_done", DW'(done), DW'(0));
    tick();
    chk_idle("err_after");
  endtask

  initial begin
    // reset state
    #2;
    chk_idle("reset");
    chk("reset_din", din, '0);
    chk("reset_snk_data", snk_data, '0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_idle("post_reset");

    // four-beat LOAD with a continuous source
    run_load(4, 100, -1);
    // two-beat STORE, sink always ready
    run_store(2, 0, 0);
    // STORE with a five-cycle sink stall on the first beat
    run_store(2, 0, 5);
    // invalid modes
    bad_mode(2'b11);
    bad_mode(2'b00);
    // stray init during an active LOAD
    run_load(5, 60, 2);
    // maximum length
    run_load(256, 100, -1);

    // randomized mix
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(1)) run_load($urandom_range(1, 9), $urandom_range(30, 100), $urandom_range(1) ? -1 : 1);
      else run_store($urandom_range(1, 6), $urandom_range(3), -1);
    end

    // reset mid-LOAD after two of four beats
    axi_sm_mode = 2'b01; txn_len = LW'(4); init_axi_txn = 1'b1;
    tick();
    init_axi_txn = 1'b0;
    src_valid = 1'b1;
    src_data = rnd_word(); tick();
    src_data = rnd_word(); tick();
    src_valid = 1'b0;
    chk("pre_rst_busy", DW'(busy), DW'(1));
    reset = 1'b1;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_din", din, '0);
    chk("mid_reset_snk_data", snk_data, '0);
    last_din = '0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("rst_release");
    end
    run_load(1, 100, -1);
    run_store(1, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sa_host_responder.md
SA_HOST_RESPONDER -- requirements
Module: sa_host_responder

Interface
REQ-001 The module SHALL have the parameter DIN_BITS, default 128, which is the data beat width and matches the systolic array din/dout.
REQ-002 The module SHALL have the parameter LEN_BITS, default 8, which is the width of the beat-count field.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset; port clk, input, 1 bit, rising-edge clock.
REQ-004 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The module SHALL have port axi_sm_mode, input, 2 bits, transfer mode from the array controller: 01 LOAD (host to array), 10 STORE (array to host), 00/11 invalid.
REQ-006 The module SHALL have port init_axi_txn, input, 1 bit, single-cycle transfer start strobe.
REQ-007 The module SHALL have port txn_len, input, LEN_BITS bits, number of beats; 0 encodes 2^LEN_BITS.
REQ-008 The module SHALL have port dvalid, output, 1 bit: LOAD beat-valid strobe, or STORE beat-request strobe.
REQ-009 The module SHALL have port din, output, DIN_BITS bits, LOAD beat data to the array.
REQ-010 The module SHALL have port dout, input, DIN_BITS bits, STORE beat data from the array, valid exactly 1 cycle after a dvalid request.
REQ-011 The module SHALL have port src_valid/src_ready/src_data, in/out/in, 1/1/DIN_BITS bits: host source stream for LOAD.
REQ-012 The module SHALL have port snk_valid/snk_ready/snk_data, out/in/out, 1/1/DIN_BITS bits: host sink stream for STORE.
REQ-013 The module SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-014 The module SHALL have port done, output, 1 bit, one-cycle transfer-complete pulse.
REQ-015 The module SHALL have port err, output, 1 bit, one-cycle pulse for init_axi_txn with an invalid mode.

Function
REQ-016 The module SHALL implement the states IDLE, LOAD, S_REQ, S_WAIT, S_HOLD and DONE.
REQ-017 In IDLE, init_axi_txn=1 with mode 01 SHALL latch txn_len into the beat counter and enter LOAD next cycle.
REQ-018 In IDLE, init_axi_txn=1 with mode 10 SHALL latch txn_len into the beat counter and enter S_REQ next cycle.
REQ-019 In IDLE, init_axi_txn=1 with mode 00/11 SHALL pulse err next cycle and remain in IDLE.
REQ-020 init_axi_txn SHALL be ignored in every state except IDLE; the latched mode and length SHALL not change.
REQ-021 In LOAD, src_ready SHALL be 1; a handshake at cycle t SHALL register din<=src_data and assert dvalid=1 at t+1 for exactly one cycle.
REQ-022 In LOAD, the beat counter SHALL decrement per handshake, and the final handshake SHALL move LOAD to DONE, so that the last dvalid and done coincide.
REQ-023 In LOAD, src_valid low SHALL insert bubbles: dvalid=0 and din holding its last value.
REQ-024 In S_REQ, the module SHALL drive dvalid=1 for one cycle and then move to S_WAIT.
REQ-025 In S_WAIT, the module SHALL capture dout into snk_data, set snk_valid=1 and move to S_HOLD.
REQ-026 In S_HOLD, snk_valid/snk_data SHALL hold until snk_ready=1, after which the counter decrements and the state moves to S_REQ if beats remain, else to DONE.
REQ-027 STORE SHALL keep exactly one request outstanding, giving a peak rate of 1 beat per 3 cycles.
REQ-028 DONE SHALL last exactly one cycle, assert done=1, and then move to IDLE; a new init_axi_txn SHALL be accepted in the cycle after DONE.
REQ-029 src_ready SHALL be 0 outside LOAD, and snk_valid SHALL be 0 outside S_HOLD.
REQ-030 txn_len=0 SHALL transfer 256 beats when LEN_BITS=8; the counter SHALL wrap-check on "last beat", not on zero-before-decrement.

Reset
REQ-031 On reset asserted, at any time including mid-transfer, state SHALL be IDLE, the beat counter 0, dvalid/src_ready/snk_valid/busy/done/err 0, and din/snk_data all zero.
REQ-032 Reset deassertion SHALL produce no done or err pulse, and a partial transfer SHALL be discarded without completion.

Verification
REQ-033 LOAD with len=4 and src_valid held 1 SHALL give dvalid high for 4 consecutive cycles carrying beats A,B,C,D in order, with done coinciding with beat D, busy low the next cycle, and no err.
REQ-034 STORE with len=2, dout returning X then Y one cycle after each dvalid, and snk_ready=1 SHALL give 2 dvalid pulses 3 cycles apart, snk_data X then Y, and a done pulse.
REQ-035 STORE with snk_ready held 0 for 5 cycles SHALL keep snk_valid and snk_data stable, and issue no further dvalid until the handshake.
REQ-036 init_axi_txn with mode 11 SHALL pulse err for 1 cycle with busy, dvalid and done staying 0; a second init_axi_txn during an active LOAD SHALL be ignored.
REQ-037 LOAD with len=0 SHALL produce exactly 256 dvalid pulses and then done.
REQ-038 Reset asserted after 2 of 4 LOAD beats SHALL force all outputs to 0 immediately, and a subsequent len=1 LOAD SHALL complete normally.
